// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default buffer geometry used by the RFID encoder/decoder
// and a constant clog2 for deriving address widths at elaboration time.
package fifo_pkg;

    localparam int unsigned DefaultDataW = 8;
    localparam int unsigned DefaultDepth = 16;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array with a synchronous write port and a registered,
// read-enabled read port. Only the read register is reset; the array is not.
module fifo_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with registered read data, occupancy count,
// almost-full/empty thresholds, synchronous flush and sticky error flags.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = DefaultDataW,
    parameter int unsigned DEPTH     = DefaultDepth,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic                      clear,
    input  logic                      write,
    input  logic [DATA_W-1:0]         data_in,
    input  logic                      read,
    output logic [DATA_W-1:0]         data_out,
    output logic                      rd_valid,
    output logic                      empty,
    output logic                      full,
    output logic                      almost_empty,
    output logic                      almost_full,
    output logic [clog2(DEPTH):0]     count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int unsigned ADDR_W = clog2(DEPTH);
    localparam logic [ADDR_W:0] CntDepth = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CntAf    = (ADDR_W + 1)'(AF_THRESH);
    localparam logic [ADDR_W:0] CntAe    = (ADDR_W + 1)'(AE_THRESH);
    localparam logic [ADDR_W:0] CntOne   = (ADDR_W + 1)'(1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two, at least 2");
    end
    if (!(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
        $error("sync_fifo_param: need AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] count_q, count_d;
    logic            rd_valid_q, rd_valid_d;
    logic            overflow_q, overflow_d;
    logic            underflow_q, underflow_d;
    logic            wr_acc, rd_acc;

    // Flags decode only the registered count, never same-cycle requests.
    assign empty        = (count_q == '0);
    assign full         = (count_q == CntDepth);
    assign almost_empty = (count_q <= CntAe);
    assign almost_full  = (count_q >= CntAf);

    always_comb begin
        wr_acc      = 1'b0;
        rd_acc      = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else if (en) begin
            wr_acc      = write && !full;
            rd_acc      = read && !empty;
            overflow_d  = overflow_q | (write && full);
            underflow_d = underflow_q | (read && empty);
            rd_valid_d  = rd_acc;
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + CntOne;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + CntOne;
            end
            if (wr_acc && !rd_acc) begin
                count_d = count_q + CntOne;
            end else if (rd_acc && !wr_acc) begin
                count_d = count_q - CntOne;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q[ADDR_W-1:0]),
        .wr_data (data_in),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr_q[ADDR_W-1:0]),
        .rd_data (data_out)
    );

    assign count     = count_q;
    assign rd_valid  = rd_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised FIFO. It is the successor to the fixed 8-bit, dual-clock buffer.
- Data width and depth are configurable. Storage is fully addressed at any depth, not a hard-coded 4-entry case.
- Adds registered read data, an occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags.
- Sits between the RFID baseband decoder/encoder and the command processor as the shared byte/word buffer.

Parameters:
- DATA_W, 8, width of each stored word in bits.
- DEPTH, 16, number of entries; must be a power of two, at least 2.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH.
- ADDR_W, clog2(DEPTH), derived locally; not overridable.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  block enable; when low, read/write are ignored and all state is held.
- clear  in  1  synchronous flush; empties the FIFO and clears the error flags.
- write  in  1  write request.
- data_in  in  DATA_W  write data.
- read  in  1  read request.
- data_out  out  DATA_W  registered read data.
- rd_valid  out  1  high for one cycle when data_out was updated by an accepted read.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count <= AE_THRESH.
- almost_full  out  1  count >= AF_THRESH.
- count  out  ADDR_W+1  current occupancy, range 0..DEPTH.
- overflow  out  1  sticky; a write was attempted while full.
- underflow  out  1  sticky; a read was attempted while empty.

Behaviour:
- Reset (reset_n low, asynchronous, any time including mid-transfer):
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - data_out = 0, rd_valid = 0, overflow = 0, underflow = 0.
  - Resulting flags: empty = 1, full = 0, almost_empty = 1, almost_full = 0 (given AF_THRESH > 0).
  - Memory contents are not reset.
- Pointers:
  - ADDR_W+1 bits wide; natural binary wrap at 2*DEPTH.
  - Memory is addressed by ptr[ADDR_W-1:0].
  - DEPTH-1 to 0 wrap needs no special-case logic.
- Accept rules (evaluated only when en = 1 and clear = 0):
  - wr_acc = write && !full
  - rd_acc = read && !empty
  - empty and full are taken from the current registered count, not from same-cycle requests.
- Write: on wr_acc, mem[wr_ptr] <= data_in; wr_ptr increments.
- Read:
  - On rd_acc: data_out <= mem[rd_ptr]; rd_ptr increments; rd_valid = 1 on the next cycle.
  - Read latency is 1 clock from request to data.
  - Without rd_acc, data_out holds its value and rd_valid = 0.
- Count update: count <= count + wr_acc - rd_acc. Simultaneous accepted read and write leaves count unchanged.
- Full with read and write in the same cycle: read accepted, write rejected, overflow set. There is no pass-through.
- Empty with read and write in the same cycle: write accepted, read rejected, underflow set. The data becomes readable the next cycle; there is no fall-through.
- overflow: set by write && full && en. underflow: set by read && empty && en. Both hold until clear or reset.
- clear = 1 (with en either value), highest priority after reset:
  - Pointers and count go to 0; overflow and underflow go to 0.
  - rd_valid = 0; data_out holds.
  - Requests in the same cycle are discarded.
- en = 0:
  - Pointers, count, data_out and flags all hold.
  - rd_valid = 0; no error flags set.
  - Unlike the previous generation, disable does not flush.
- Status flags are combinational decodes of the registered count and change only after a clock edge.
- Elaboration-time checks: DEPTH is a power of two; AE_THRESH < AF_THRESH <= DEPTH.

Decomposition:
- Shared package fifo_pkg holds:
  - a clog2 constant function;
  - default DATA_W/DEPTH localparams shared with the encoder/decoder.
- One sub-module, fifo_mem:
  - DEPTH x DATA_W register array;
  - synchronous write port;
  - synchronous registered read port with read enable;
  - no reset on the array.
- Pointer, count, flag and error logic lives in sync_fifo_param.

Test Plan:
- Reset then idle: reset_n low 2 cycles, release, en = 1 -> count = 0, empty = 1, almost_empty = 1, full = 0, data_out = 0, overflow = underflow = 0.
- Fill and drain: write 0xA1..0xB0 (16 words, DEPTH = 16) -> full = 1, almost_full from count = 14. Read 16 -> data_out = 0xA1..0xB0 in order, each one cycle after its read, with rd_valid pulses. Then empty = 1.
- Wrap-around: 3 rounds of write 10 / read 10 with distinct data -> pointers wrap past 15, order preserved, count returns to 0 each round.
- Boundary simultaneous requests:
  - At full, read + write with data_in = 0x55 -> count = 15, overflow = 1, and 0x55 is never read.
  - At empty, read + write with data_in = 0x66 -> count = 1, underflow = 1, next read returns 0x66.
- Control:
  - en = 0 with write = 1 for 5 cycles at count = 3 -> count stays 3, no flag changes.
  - clear = 1 at count = 7 with overflow set -> count = 0, empty = 1, overflow = 0.
  - reset_n low mid-burst -> all outputs take their reset values immediately, without a clock edge.
